// File: rtl/exc_pkg.sv
// ---------------------------------------------------------------------------
// exc_pkg : shared encodings for the exception entry sequencer. Rev 1.0
// Optional build macro EXC_RETURN_EN adds the RET state to the FSM enum.
// ---------------------------------------------------------------------------
`default_nettype none

package exc_pkg;

  // Processor mode encodings, identical to the shared common header
  localparam logic [4:0] MODE_USR = 5'b10000;
  localparam logic [4:0] MODE_FIQ = 5'b10001;
  localparam logic [4:0] MODE_IRQ = 5'b10010;
  localparam logic [4:0] MODE_SVC = 5'b10011;
  localparam logic [4:0] MODE_ABT = 5'b10111;
  localparam logic [4:0] MODE_UND = 5'b11011;
  localparam logic [4:0] MODE_SYS = 5'b11111;

  localparam int EXC_UND  = 0;
  localparam int EXC_SWI  = 1;
  localparam int EXC_PABT = 2;
  localparam int EXC_DABT = 3;
  localparam int EXC_IRQ  = 4;
  localparam int EXC_FIQ  = 5;

  localparam logic [31:0] VEC_UND  = 32'h0000_0004;
  localparam logic [31:0] VEC_SWI  = 32'h0000_0008;
  localparam logic [31:0] VEC_PABT = 32'h0000_000C;
  localparam logic [31:0] VEC_DABT = 32'h0000_0010;
  localparam logic [31:0] VEC_IRQ  = 32'h0000_0018;
  localparam logic [31:0] VEC_FIQ  = 32'h0000_001C;

  localparam logic [31:0] LR_OFF_STD  = 32'd4;
  localparam logic [31:0] LR_OFF_DABT = 32'd8;

  localparam int CPSR_I = 7;
  localparam int CPSR_F = 6;
  localparam int CPSR_T = 5;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SAVE = 3'd1,
    ST_BANK = 3'd2,
    ST_DONE = 3'd3
`ifdef EXC_RETURN_EN
    ,
    ST_RET  = 3'd4
`endif
  } exc_state_e;

endpackage

`default_nettype wire

// File: rtl/exc_prio_enc.sv
// ---------------------------------------------------------------------------
// exc_prio_enc : masks IRQ/FIQ and picks the highest-priority request. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module exc_prio_enc
  import exc_pkg::*;
(
  input  logic [5:0]  exc_req,
  input  logic        irq_mask,
  input  logic        fiq_mask,
  output logic        valid,
  output logic [5:0]  onehot,
  output logic [4:0]  mode,
  output logic [31:0] lr_off,
  output logic [31:0] vec_off
);

  logic [5:0] live;

  always_comb begin
    live           = exc_req;
    live[EXC_IRQ]  = exc_req[EXC_IRQ] & ~irq_mask;
    live[EXC_FIQ]  = exc_req[EXC_FIQ] & ~fiq_mask;
    onehot         = 6'b000000;
    mode           = 5'b00000;
    lr_off         = LR_OFF_STD;
    vec_off        = 32'd0;
    // DABT > FIQ > IRQ > PABT > UND > SWI
    if (live[EXC_DABT]) begin
      onehot[EXC_DABT] = 1'b1;
      mode             = MODE_ABT;
      lr_off           = LR_OFF_DABT;
      vec_off          = VEC_DABT;
    end else if (live[EXC_FIQ]) begin
      onehot[EXC_FIQ]  = 1'b1;
      mode             = MODE_FIQ;
      vec_off          = VEC_FIQ;
    end else if (live[EXC_IRQ]) begin
      onehot[EXC_IRQ]  = 1'b1;
      mode             = MODE_IRQ;
      vec_off          = VEC_IRQ;
    end else if (live[EXC_PABT]) begin
      onehot[EXC_PABT] = 1'b1;
      mode             = MODE_ABT;
      vec_off          = VEC_PABT;
    end else if (live[EXC_UND]) begin
      onehot[EXC_UND]  = 1'b1;
      mode             = MODE_UND;
      vec_off          = VEC_UND;
    end else if (live[EXC_SWI]) begin
      onehot[EXC_SWI]  = 1'b1;
      mode             = MODE_SVC;
      vec_off          = VEC_SWI;
    end
  end

  assign valid = |live;

endmodule

`default_nettype wire

// File: rtl/exc_entry_ctrl.sv
// ---------------------------------------------------------------------------
// exc_entry_ctrl : ARM32 exception entry sequencer driving the regfile write side.
// Optional build macro EXC_RETURN_EN adds the SPSR->CPSR return path. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module exc_entry_ctrl
  import exc_pkg::*;
#(
  parameter logic [31:0] VECTOR_BASE = 32'h0000_0000
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic [5:0]  exc_req,
  input  logic [31:0] exc_pc,
  input  logic [31:0] CPSR_out,
`ifdef EXC_RETURN_EN
  input  logic        ret_req,
  input  logic [31:0] ret_pc,
  input  logic [31:0] SPSR_out,
  output logic        ret_ack,
`endif
  output logic        busy,
  output logic        exc_ack,
  output logic [5:0]  exc_taken,
  output logic [31:0] CPSR_in,
  output logic        CPSR_write_en,
  output logic [3:0]  CPSR_byte_w_en,
  output logic [31:0] SPSR_in,
  output logic        SPSR_write_en,
  output logic [3:0]  SPSR_byte_w_en,
  output logic [4:0]  Rn_w_addr,
  output logic [31:0] Rn_in,
  output logic [3:0]  Rn_byte_w_en,
  output logic [31:0] PC_in,
  output logic        pc_write_en
);

  exc_state_e  state_q, state_d;
  logic [5:0]  taken_q, taken_d;
  logic [4:0]  mode_q, mode_d;
  logic [31:0] old_cpsr_q, old_cpsr_d;
  logic [31:0] lr_q, lr_d;
  logic [31:0] vec_q, vec_d;
`ifdef EXC_RETURN_EN
  logic        is_ret_q, is_ret_d;
`endif

  logic        pe_valid;
  logic [5:0]  pe_onehot;
  logic [4:0]  pe_mode;
  logic [31:0] pe_lr_off;
  logic [31:0] pe_vec_off;

  exc_prio_enc u_prio (
    .exc_req  (exc_req),
    .irq_mask (CPSR_out[CPSR_I]),
    .fiq_mask (CPSR_out[CPSR_F]),
    .valid    (pe_valid),
    .onehot   (pe_onehot),
    .mode     (pe_mode),
    .lr_off   (pe_lr_off),
    .vec_off  (pe_vec_off)
  );

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state_q    <= ST_IDLE;
      taken_q    <= 6'b000000;
      mode_q     <= 5'b00000;
      old_cpsr_q <= 32'd0;
      lr_q       <= 32'd0;
      vec_q      <= 32'd0;
`ifdef EXC_RETURN_EN
      is_ret_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      taken_q    <= taken_d;
      mode_q     <= mode_d;
      old_cpsr_q <= old_cpsr_d;
      lr_q       <= lr_d;
      vec_q      <= vec_d;
`ifdef EXC_RETURN_EN
      is_ret_q   <= is_ret_d;
`endif
    end
  end

  always_comb begin
    state_d        = state_q;
    taken_d        = taken_q;
    mode_d         = mode_q;
    old_cpsr_d     = old_cpsr_q;
    lr_d           = lr_q;
    vec_d          = vec_q;
`ifdef EXC_RETURN_EN
    is_ret_d       = is_ret_q;
    ret_ack        = 1'b0;
`endif
    busy           = 1'b0;
    exc_ack        = 1'b0;
    exc_taken      = 6'b000000;
    CPSR_in        = 32'd0;
    CPSR_write_en  = 1'b0;
    CPSR_byte_w_en = 4'b1111;
    SPSR_in        = 32'd0;
    SPSR_write_en  = 1'b0;
    SPSR_byte_w_en = 4'b1111;
    Rn_w_addr      = 5'd0;
    Rn_in          = 32'd0;
    Rn_byte_w_en   = 4'b1111;
    PC_in          = 32'd0;
    pc_write_en    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (pe_valid) begin
          state_d    = ST_SAVE;
          taken_d    = pe_onehot;
          mode_d     = pe_mode;
          old_cpsr_d = CPSR_out;
          lr_d       = exc_pc + pe_lr_off;
          vec_d      = VECTOR_BASE + pe_vec_off;
`ifdef EXC_RETURN_EN
          is_ret_d   = 1'b0;
`endif
        end
`ifdef EXC_RETURN_EN
        else if (ret_req) begin
          state_d  = ST_RET;
          taken_d  = 6'b000000;
          is_ret_d = 1'b1;
        end
`endif
      end
      ST_SAVE: begin
        // Only byte 0 changes; the regfile banks on the new mode from next cycle
        busy           = 1'b1;
        exc_taken      = taken_q;
        CPSR_in        = {old_cpsr_q[31:8], 1'b1,
                          taken_q[EXC_FIQ] | old_cpsr_q[CPSR_F], 1'b0, mode_q};
        CPSR_write_en  = 1'b1;
        CPSR_byte_w_en = 4'b1110;
        state_d        = ST_BANK;
      end
      ST_BANK: begin
        busy           = 1'b1;
        exc_taken      = taken_q;
        SPSR_in        = old_cpsr_q;
        SPSR_write_en  = 1'b1;
        SPSR_byte_w_en = 4'b0000;
        Rn_w_addr      = 5'd14;
        Rn_in          = lr_q;
        Rn_byte_w_en   = 4'b0000;
        PC_in          = vec_q;
        pc_write_en    = 1'b1;
        state_d        = ST_DONE;
      end
      ST_DONE: begin
        exc_taken = taken_q;
        state_d   = ST_IDLE;
`ifdef EXC_RETURN_EN
        if (is_ret_q) ret_ack = 1'b1;
        else          exc_ack = 1'b1;
`else
        exc_ack   = 1'b1;
`endif
      end
`ifdef EXC_RETURN_EN
      ST_RET: begin
        busy           = 1'b1;
        CPSR_in        = SPSR_out;
        CPSR_write_en  = 1'b1;
        CPSR_byte_w_en = 4'b0000;
        PC_in          = ret_pc;
        pc_write_en    = 1'b1;
        state_d        = ST_DONE;
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_exc_entry_ctrl.sv
// ---------------------------------------------------------------------------
// tb_exc_entry_ctrl : table-driven and randomized checks of exc_entry_ctrl.
// ---------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_exc_entry_ctrl;

  localparam logic [31:0] VB = 32'h0000_0000;

  logic        Clk = 1'b0;
  logic        Rst;
  logic [5:0]  exc_req;
  logic [31:0] exc_pc;
  logic [31:0] CPSR_out;
  logic        busy, exc_ack;
  logic [5:0]  exc_taken;
  logic [31:0] CPSR_in, SPSR_in, Rn_in, PC_in;
  logic        CPSR_write_en, SPSR_write_en, pc_write_en;
  logic [3:0]  CPSR_byte_w_en, SPSR_byte_w_en, Rn_byte_w_en;
  logic [4:0]  Rn_w_addr;
`ifdef EXC_RETURN_EN
  logic        ret_req;
  logic [31:0] ret_pc, SPSR_out;
  logic        ret_ack;
`endif

  always #5 Clk = ~Clk;

  exc_entry_ctrl #(.VECTOR_BASE(VB)) dut (
    .Clk            (Clk),
    .Rst            (Rst),
    .exc_req        (exc_req),
    .exc_pc         (exc_pc),
    .CPSR_out       (CPSR_out),
`ifdef EXC_RETURN_EN
    .ret_req        (ret_req),
    .ret_pc         (ret_pc),
    .SPSR_out       (SPSR_out),
    .ret_ack        (ret_ack),
`endif
    .busy           (busy),
    .exc_ack        (exc_ack),
    .exc_taken      (exc_taken),
    .CPSR_in        (CPSR_in),
    .CPSR_write_en  (CPSR_write_en),
    .CPSR_byte_w_en (CPSR_byte_w_en),
    .SPSR_in        (SPSR_in),
    .SPSR_write_en  (SPSR_write_en),
    .SPSR_byte_w_en (SPSR_byte_w_en),
    .Rn_w_addr      (Rn_w_addr),
    .Rn_in          (Rn_in),
    .Rn_byte_w_en   (Rn_byte_w_en),
    .PC_in          (PC_in),
    .pc_write_en    (pc_write_en)
  );

  typedef struct {
    logic [31:0] cpsr;
    logic [31:0] pc;
    logic [5:0]  req;
    logic [5:0]  taken;
    logic [31:0] exp_cpsr;
    logic [31:0] exp_spsr;
    logic [31:0] exp_lr;
    logic [31:0] exp_pc;
  } vec_t;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req_val);
    checks++;
    if (act !== req_val) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, req_val);
    end
  endtask

  // Reference: architectural entry rules straight from the exception tables
  function automatic vec_t model(input logic [31:0] c, input logic [31:0] pc, input logic [5:0] rq);
    vec_t        v;
    int          order [6]  = '{3, 5, 4, 2, 0, 1};
    int          lr_add [6] = '{4, 4, 4, 8, 4, 4};
    int          voff [6]   = '{4, 8, 12, 16, 24, 28};
    logic [4:0]  modes [6]  = '{5'h1B, 5'h13, 5'h17, 5'h17, 5'h12, 5'h11};
    int          e = -1;
    v = '{c, pc, rq, 6'd0, 32'd0, 32'd0, 32'd0, 32'd0};
    for (int k = 0; k < 6; k++) begin
      if (e < 0 && rq[order[k]] && !(order[k] == 4 && c[7]) && !(order[k] == 5 && c[6]))
        e = order[k];
    end
    if (e >= 0) begin
      v.taken    = 6'b000001 << e;
      v.exp_cpsr = {c[31:8], 1'b1, (e == 5) ? 1'b1 : c[6], 1'b0, modes[e]};
      v.exp_spsr = c;
      v.exp_lr   = pc + 32'(lr_add[e]);
      v.exp_pc   = VB + 32'(voff[e]);
    end
    return v;
  endfunction

  task automatic run_entry(input string nm, input vec_t v);
    exc_req  = v.req;
    CPSR_out = v.cpsr;
    exc_pc   = v.pc;
    @(posedge Clk); #1;
    // The regfile CPSR and pipeline PC move on; the sequence must use latched copies
    CPSR_out = $urandom;
    exc_pc   = $urandom;
    chk({nm, ".save_busy"},   32'(busy), 32'd1);
    chk({nm, ".save_cwe"},    32'(CPSR_write_en), 32'd1);
    chk({nm, ".save_cpsr"},   CPSR_in, v.exp_cpsr);
    chk({nm, ".save_cbe"},    32'(CPSR_byte_w_en), 32'hE);
    chk({nm, ".save_taken"},  32'(exc_taken), 32'(v.taken));
    chk({nm, ".save_others"}, 32'({SPSR_write_en, pc_write_en, Rn_byte_w_en}), 32'h0F);
    @(posedge Clk); #1;
    chk({nm, ".bank_spsr"},   SPSR_in, v.exp_spsr);
    chk({nm, ".bank_swe"},    32'({SPSR_write_en, SPSR_byte_w_en}), 32'h10);
    chk({nm, ".bank_rn"},     32'({Rn_w_addr, Rn_byte_w_en}), 32'({5'd14, 4'b0000}));
    chk({nm, ".bank_lr"},     Rn_in, v.exp_lr);
    chk({nm, ".bank_pc"},     PC_in, v.exp_pc);
    chk({nm, ".bank_strb"},   32'({pc_write_en, CPSR_write_en, busy}), 32'b101);
    chk({nm, ".bank_taken"},  32'(exc_taken), 32'(v.taken));
    @(posedge Clk); #1;
    chk({nm, ".done_ack"},    32'({exc_ack, busy}), 32'b10);
    chk({nm, ".done_strb"},   32'({CPSR_write_en, SPSR_write_en, pc_write_en, Rn_byte_w_en}), 32'h0F);
    exc_req = 6'b000000;
    @(posedge Clk); #1;
    chk({nm, ".idle"},        32'({exc_ack, busy, exc_taken}), 32'd0);
  endtask

  vec_t tbl [11];
  vec_t rv;
  logic saw_ack;

  initial begin
    tbl[0]  = '{32'h10,       32'h100,      6'b000010, 6'b000010, 32'h93,       32'h10,       32'h104,  32'h08};
    tbl[1]  = '{32'h10,       32'h300,      6'b010000, 6'b010000, 32'h92,       32'h10,       32'h304,  32'h18};
    tbl[2]  = '{32'h10,       32'h200,      6'b011001, 6'b001000, 32'h97,       32'h10,       32'h208,  32'h10};
    tbl[3]  = '{32'h92,       32'h400,      6'b100000, 6'b100000, 32'hD1,       32'h92,       32'h404,  32'h1C};
    tbl[4]  = '{32'h92,       32'hFFFFFFFC, 6'b100000, 6'b100000, 32'hD1,       32'h92,       32'h0,    32'h1C};
    tbl[5]  = '{32'h13,       32'h50,       6'b000001, 6'b000001, 32'h9B,       32'h13,       32'h54,   32'h04};
    tbl[6]  = '{32'h600000D3, 32'h80,       6'b000100, 6'b000100, 32'h600000D7, 32'h600000D3, 32'h84,   32'h0C};
    tbl[7]  = '{32'h51,       32'h1000,     6'b110000, 6'b010000, 32'hD2,       32'h51,       32'h1004, 32'h18};
    tbl[8]  = '{32'h30,       32'h20,       6'b000010, 6'b000010, 32'h93,       32'h30,       32'h24,   32'h08};
    tbl[9]  = '{32'h1F,       32'h8,        6'b000111, 6'b000100, 32'h97,       32'h1F,       32'hC,    32'h0C};
    tbl[10] = '{32'h13,       32'h60,       6'b000010, 6'b000010, 32'h93,       32'h13,       32'h64,   32'h08};

    Rst = 1'b0; exc_req = 6'b100001; exc_pc = 32'h1234; CPSR_out = 32'h10;
`ifdef EXC_RETURN_EN
    ret_req = 1'b0; ret_pc = 32'd0; SPSR_out = 32'd0;
`endif
    repeat (3) @(posedge Clk);
    #1;
    chk("reset.ctrl", 32'({busy, exc_ack, exc_taken}), 32'd0);
    chk("reset.strb", 32'({CPSR_write_en, SPSR_write_en, pc_write_en}), 32'd0);
    chk("reset.ben",  32'({CPSR_byte_w_en, SPSR_byte_w_en, Rn_byte_w_en}), 32'hFFF);
    chk("reset.data", CPSR_in | SPSR_in | Rn_in | PC_in | 32'(Rn_w_addr), 32'd0);
    exc_req = 6'b000000;
    Rst = 1'b1;
    @(posedge Clk); #1;

    for (int i = 0; i < 11; i++) run_entry($sformatf("tbl%0d", i), tbl[i]);

    // Masked IRQ must leave the sequencer idle
    CPSR_out = 32'hD3; exc_req = 6'b010000; exc_pc = 32'h500;
    for (int i = 0; i < 10; i++) begin
      @(posedge Clk); #1;
      chk("irq_masked", 32'({busy, CPSR_write_en, SPSR_write_en, pc_write_en, exc_ack}), 32'd0);
    end
    CPSR_out = 32'h40; exc_req = 6'b100000;
    for (int i = 0; i < 4; i++) begin
      @(posedge Clk); #1;
      chk("fiq_masked", 32'({busy, CPSR_write_en, exc_ack}), 32'd0);
    end
    exc_req = 6'b000000;
    run_entry("irq_unmasked", model(32'h10, 32'h500, 6'b010000));

    // Reset while in BANK abandons the sequence
    exc_req = 6'b000010; CPSR_out = 32'h10; exc_pc = 32'h100;
    @(posedge Clk); #1;
    @(posedge Clk); #1;
    chk("rst_mid.in_bank", 32'({pc_write_en, busy}), 32'b11);
    Rst = 1'b0; exc_req = 6'b000000;
    @(posedge Clk); #1;
    chk("rst_mid.strb", 32'({busy, exc_ack, CPSR_write_en, SPSR_write_en, pc_write_en}), 32'd0);
    chk("rst_mid.ben",  32'({CPSR_byte_w_en, SPSR_byte_w_en, Rn_byte_w_en}), 32'hFFF);
    chk("rst_mid.data", CPSR_in | SPSR_in | Rn_in | PC_in, 32'd0);
    Rst = 1'b1;
    saw_ack = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge Clk); #1;
      saw_ack = saw_ack | exc_ack;
    end
    chk("rst_mid.no_ack", 32'(saw_ack), 32'd0);

    // Randomized entries against the reference model
    for (int i = 0; i < 40; i++) begin
      rv = model($urandom, $urandom, 6'($urandom_range(1, 63)));
      if (rv.taken == 6'd0) begin
        exc_req = rv.req; CPSR_out = rv.cpsr; exc_pc = rv.pc;
        repeat (2) @(posedge Clk);
        #1;
        chk($sformatf("rnd%0d.masked", i), 32'({busy, CPSR_write_en, exc_ack}), 32'd0);
        exc_req = 6'b000000;
      end else begin
        run_entry($sformatf("rnd%0d", i), rv);
      end
    end

`ifdef EXC_RETURN_EN
    SPSR_out = 32'h10; ret_pc = 32'h104; ret_req = 1'b1; CPSR_out = 32'h13;
    @(posedge Clk); #1;
    chk("ret.cpsr", CPSR_in, 32'h10);
    chk("ret.cwe",  32'({CPSR_write_en, CPSR_byte_w_en, busy}), 32'b1_0000_1);
    chk("ret.pc",   PC_in, 32'h104);
    chk("ret.pwe",  32'({pc_write_en, SPSR_write_en, Rn_byte_w_en}), 32'b1_0_1111);
    @(posedge Clk); #1;
    chk("ret.ack",  32'({ret_ack, exc_ack, busy}), 32'b100);
    ret_req = 1'b0;
    @(posedge Clk); #1;
    chk("ret.idle", 32'({ret_ack, busy}), 32'd0);
    ret_req = 1'b1; exc_req = 6'b000010; CPSR_out = 32'h10;
    @(posedge Clk); #1;
    chk("ret_vs_exc.save", 32'({CPSR_byte_w_en, busy}), 32'b1110_1);
    @(posedge Clk); #1;
    @(posedge Clk); #1;
    chk("ret_vs_exc.ack", 32'({exc_ack, ret_ack}), 32'b10);
    ret_req = 1'b0; exc_req = 6'b000000;
    @(posedge Clk); #1;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/exc_entry_ctrl.md
Name: exc_entry_ctrl

Overview:
Exception entry sequencer that drives the write side of the ARM32 banked register file (regfile).
- Takes prioritised exception requests and performs the architectural entry sequence:
  - SPSR_<mode> <= CPSR
  - R14_<mode> <= return address
  - CPSR mode, I and F bits updated, T cleared
  - PC <= vector
- Runs multi-cycle because banked SPSR/R14 selection follows the current CPSR mode, so the mode must switch first.
- Sits between the pipeline's exception sources and the regfile write-port mux; stalls the pipeline while busy.

Parameters:
VECTOR_BASE, 32'h00000000, exception vector base (32'hFFFF0000 for high vectors)

Ports:
Clk  in  1  clock, all state updates on rising edge
Rst  in  1  reset, synchronous, active-low
exc_req  in  6  level requests [0]UND [1]SWI [2]PABT [3]DABT [4]IRQ [5]FIQ; held by source until exc_ack
exc_pc  in  32  address of the instruction associated with the exception
CPSR_out  in  32  current CPSR from regfile
busy  out  1  sequence in progress; pipeline stall
exc_ack  out  1  one-cycle pulse; sequence complete
exc_taken  out  6  one-hot type being serviced; valid while busy or exc_ack
CPSR_in  out  32  CPSR write data
CPSR_write_en  out  1  CPSR write strobe, active-high
CPSR_byte_w_en  out  4  CPSR byte enables, active-low (4'b0000 = all bytes)
SPSR_in  out  32  SPSR write data (bank chosen by regfile from current mode)
SPSR_write_en  out  1  SPSR write strobe, active-high
SPSR_byte_w_en  out  4  SPSR byte enables, active-low
Rn_w_addr  out  5  Rn write address
Rn_in  out  32  Rn write data
Rn_byte_w_en  out  4  Rn byte enables, active-low; 4'b1111 = no write
PC_in  out  32  PC write data
pc_write_en  out  1  PC write strobe, active-high

Behaviour:
- Reset (Rst low at an edge), including mid-sequence:
  - state IDLE; busy=0, exc_ack=0, exc_taken=0
  - CPSR_write_en=0, SPSR_write_en=0, pc_write_en=0
  - all byte enables 4'b1111; data outputs 0
  - any partially completed sequence is abandoned; no further writes
- Masking: IRQ ignored when CPSR_out[7]=1; FIQ ignored when CPSR_out[6]=1.
- Priority, highest first: DABT > FIQ > IRQ > PABT > UND > SWI.
- Targets:
  - UND: mode 11011, LR +4, vector +0x04
  - SWI: mode 10011, LR +4, vector +0x08
  - PABT: mode 10111, LR +4, vector +0x0C
  - DABT: mode 10111, LR +8, vector +0x10
  - IRQ: mode 10010, LR +4, vector +0x18
  - FIQ: mode 10001, LR +4, vector +0x1C
  - LR arithmetic is 32-bit modulo (0xFFFFFFFC+8 wraps to 0x4).
- IDLE: all write strobes inactive. On any unmasked request, latch type, exc_pc and old CPSR, then go to SAVE. Output strobes become active from the next cycle.
- SAVE, 1 cycle:
  - CPSR_in = {old[31:8], I=1, F=(FIQ ? 1 : old[6]), T=0, new_mode}
  - CPSR_write_en=1, CPSR_byte_w_en=4'b1110 (byte 0 only)
  - busy=1 → BANK
- BANK, 1 cycle; regfile now banks on the new mode:
  - SPSR_in = latched old CPSR, SPSR_write_en=1, SPSR_byte_w_en=4'b0000
  - Rn_w_addr=14, Rn_in=LR, Rn_byte_w_en=4'b0000
  - PC_in=VECTOR_BASE+offset, pc_write_en=1
  - busy=1 → DONE
- DONE, 1 cycle: exc_ack=1, busy=0, all strobes inactive → IDLE.
- Entry latency: request sampled in IDLE → first write 1 cycle later → ack 3 cycles later.
- Requests are not sampled in SAVE, BANK or DONE. A request still held after ack is re-evaluated in IDLE, so sources must drop on ack.
- Entry from the same mode (e.g. SWI while in SVC) overwrites that mode's SPSR/R14 with no special case.

Optional Feature:
EXC_RETURN_EN
- When defined, adds ports: ret_req in 1, ret_pc in 32, SPSR_out in 32, ret_ack out 1.
- In IDLE with ret_req=1 and no unmasked exc_req, go to RET for 1 cycle:
  - CPSR_in=SPSR_out, CPSR_write_en=1, CPSR_byte_w_en=4'b0000
  - PC_in=ret_pc, pc_write_en=1, busy=1
- Then DONE, which pulses ret_ack in place of exc_ack.
- exc_req wins over a simultaneous ret_req.
- When not defined, these ports and the RET state are absent.

Decomposition:
- Package exc_pkg holds:
  - mode encodings (same values as the shared common header: USE, FIQ, IRQ, SVC, ABT, UND, SYS)
  - exception index constants, vector offsets, LR offsets
  - CPSR bit positions (I=7, F=6, T=5, mode 4:0)
  - FSM state enum
- Sub-module exc_prio_enc: combinational masking plus priority encoding of exc_req/CPSR_out into a one-hot type, target mode, LR offset and vector offset.

Test Plan:
- SWI from USR: CPSR_out=0x00000010, exc_pc=0x100, exc_req=6'b000010.
  - SAVE: CPSR_in[7:0]=0x93, byte_en 4'b1110.
  - BANK: SPSR_in=0x10, Rn_w_addr=14, Rn_in=0x104, PC_in=0x08.
  - exc_ack 3 cycles after request.
- IRQ masked, then unmasked:
  - CPSR_out=0xD3 with IRQ requested → busy stays 0, no writes for 10 cycles.
  - CPSR_out=0x10 → CPSR_in[7:0]=0x92, PC_in=0x18.
- Priority: exc_req=6'b011001 with exc_pc=0x200 → DABT taken, CPSR_in[7:0]=0x97, Rn_in=0x208, PC_in=0x10.
- FIQ from IRQ mode: CPSR_out=0x92 → CPSR_in[7:0]=0xD1, SPSR_in=0x92, PC_in=0x1C; wrap case exc_pc=0xFFFFFFFC gives Rn_in=0x00000000.
- Reset mid-op: Rst low during BANK → next cycle all strobes inactive, byte enables 4'b1111, busy=0; exc_ack never pulses.
- EXC_RETURN_EN: SPSR_out=0x10, ret_pc=0x104, ret_req=1 → CPSR_in=0x10 with byte_en 4'b0000, PC_in=0x104, ret_ack one cycle later.
